riscv_wb_arbiter: RTL and testbench

Write-side companion to the register file: the only block that drives the register file write port (`wb_q_is_rd_write`, `wb_rd_addr`, `wb_rd_wdata`). It merges two result streams, the in-order MEM/WB pipeline and an out-of-band long-latency unit (divider, non-blocking load). It buffers long-latency results in a small FIFO. It keeps a 32-entry pending-write scoreboard that the ID stage uses to stall on RAW/WAW hazards against outstanding long ops.

---
 rtl/riscv_wb_arbiter.sv | 111 +++++++++++
 tb/tb_riscv_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_arbiter.sv
// Register-file write-port arbiter: merges in-order and long-latency results and tracks pending long-op destinations.
// Optional feature macro: RISCV_WB_ARB_BYPASS_EN (LU result goes straight to the write port when the FIFO is empty and the pipe is idle).
module riscv_wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pipe_valid_i,
  input  logic [4:0]  pipe_rd_addr_i,
  input  logic [31:0] pipe_rd_wdata_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_rd_addr_i,
  input  logic [31:0] lu_rd_wdata_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_addr_i,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic [31:0] pending_o,
  output logic        wb_q_is_rd_write,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_wdata
);
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  // LU handshake: a result transfers on a rising edge where lu_valid_i && lu_ready_o;
  // lu_ready_o depends only on registered FIFO state and reset, never on lu_valid_i.
  logic [36:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [31:0]   r_pending;
  logic          r_we;
  logic [4:0]    r_addr;
  logic [31:0]   r_data;

  logic          w_full;
  logic          w_empty;
  logic          w_lu_acc;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [36:0]   w_head;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;
  logic [31:0]   w_pending_nxt;

  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign lu_ready_o = rst_ni && !w_full;
  assign w_lu_acc = lu_valid_i && lu_ready_o;
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

`ifdef RISCV_WB_ARB_BYPASS_EN
  assign w_bypass = w_lu_acc && w_empty && !pipe_valid_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_lu_acc && !w_bypass;
  // The pipe never stalls, so the FIFO only drains in cycles the pipe leaves free.
  assign w_pop  = !pipe_valid_i && !w_empty;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid_i && (issue_rd_addr_i != 5'd0)) w_set = 32'(1) << issue_rd_addr_i;
    if (w_pop)         w_clr = 32'(1) << w_head[36:32];
    else if (w_bypass) w_clr = 32'(1) << lu_rd_addr_i;
    // Clear first, then set, so a same-cycle issue to the same rd keeps the bit.
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pending <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {lu_rd_addr_i, lu_rd_wdata_i};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

      r_we <= pipe_valid_i || w_pop || w_bypass;
      if (pipe_valid_i) begin
        r_addr <= pipe_rd_addr_i;
        r_data <= pipe_rd_wdata_i;
      end else if (w_pop) begin
        r_addr <= w_head[36:32];
        r_data <= w_head[31:0];
      end else if (w_bypass) begin
        r_addr <= lu_rd_addr_i;
        r_data <= lu_rd_wdata_i;
      end
    end
  end

  assign pending_o        = r_pending;
  assign rs1_busy_o       = r_pending[id_rs1_addr] && (id_rs1_addr != 5'd0);
  assign rs2_busy_o       = r_pending[id_rs2_addr] && (id_rs2_addr != 5'd0);
  assign wb_q_is_rd_write = r_we;
  assign wb_rd_addr       = r_addr;
  assign wb_rd_wdata      = r_data;
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter with hand-computed expectations; build with RISCV_WB_ARB_BYPASS_EN for the bypass variant.
module tb_riscv_wb_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        pipe_valid_i;
  logic [4:0]  pipe_rd_addr_i;
  logic [31:0] pipe_rd_wdata_i;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  lu_rd_addr_i;
  logic [31:0] lu_rd_wdata_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_addr_i;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic [31:0] pending_o;
  logic        wb_q_is_rd_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_wdata;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk_i = ~clk_i;

  riscv_wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pipe_valid_i(pipe_valid_i), .pipe_rd_addr_i(pipe_rd_addr_i), .pipe_rd_wdata_i(pipe_rd_wdata_i),
    .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
    .lu_rd_addr_i(lu_rd_addr_i), .lu_rd_wdata_i(lu_rd_wdata_i),
    .issue_valid_i(issue_valid_i), .issue_rd_addr_i(issue_rd_addr_i),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o), .pending_o(pending_o),
    .wb_q_is_rd_write(wb_q_is_rd_write), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
    pipe_valid_i = v; pipe_rd_addr_i = a; pipe_rd_wdata_i = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid_i = v; lu_rd_addr_i = a; lu_rd_wdata_i = d;
  endtask

  task automatic drive_issue(input logic v, input logic [4:0] a);
    issue_valid_i = v; issue_rd_addr_i = a;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"}, 32'(wb_q_is_rd_write), 32'(we));
    check({tag, "_addr"}, 32'(wb_rd_addr), 32'(a));
    check({tag, "_data"}, wb_rd_wdata, d);
  endtask

  initial begin
    rst_ni = 1'b0;
    drive_pipe(0, 0, 0);
    drive_lu(0, 0, 0);
    drive_issue(0, 0);
    id_rs1_addr = 0;
    id_rs2_addr = 0;

    // reset state
    tick(); tick();
    check_wr("reset", 0, 0, 0);
    check("reset_pending", pending_o, 0);
    check("reset_lu_ready", 32'(lu_ready_o), 0);
    rst_ni = 1'b1;
    tick();
    check("post_reset_lu_ready", 32'(lu_ready_o), 1);

    // in-order write, then idle holds address/data
    drive_pipe(1, 5, 32'hDEADBEEF);
    tick();
    check_wr("inorder", 1, 5, 32'hDEADBEEF);
    drive_pipe(0, 0, 0);
    tick();
    check_wr("inorder_idle", 0, 5, 32'hDEADBEEF);

    // scoreboard round trip
    drive_issue(1, 7);
    tick();
    drive_issue(0, 0);
    check("sb_pending_set", pending_o, 32'h80);
    id_rs1_addr = 7;
    #1;
    check("sb_rs1_busy", 32'(rs1_busy_o), 1);
    drive_lu(1, 7, 32'h1234);
    tick();
    drive_lu(0, 0, 0);
`ifdef RISCV_WB_ARB_BYPASS_EN
    check_wr("sb_bypass_wr", 1, 7, 32'h1234);
    check("sb_bypass_pending", pending_o, 0);
`else
    check("sb_n1_we", 32'(wb_q_is_rd_write), 0);
    check("sb_n1_pending", pending_o, 32'h80);
    tick();
    check_wr("sb_n2_wr", 1, 7, 32'h1234);
    check("sb_n2_pending", pending_o, 0);
`endif
    #1;
    check("sb_rs1_idle", 32'(rs1_busy_o), 0);

    // priority and full: pipe starves the FIFO
    drive_pipe(1, 1, 32'h11);
    drive_lu(1, 10, 32'hA);
    tick();
    check_wr("prio_p1", 1, 1, 32'h11);
    drive_pipe(1, 2, 32'h22);
    drive_lu(1, 11, 32'hB);
    tick();
    drive_lu(0, 0, 0);
    check_wr("prio_p2", 1, 2, 32'h22);
    check("prio_full_ready", 32'(lu_ready_o), 0);
    drive_pipe(1, 3, 32'h33);
    tick();
    check_wr("prio_p3", 1, 3, 32'h33);
    check("prio_still_full", 32'(lu_ready_o), 0);
    drive_pipe(0, 0, 0);
    tick();
    check_wr("drain_1", 1, 10, 32'hA);
    check("drain_ready", 32'(lu_ready_o), 1);
    tick();
    check_wr("drain_2", 1, 11, 32'hB);
    tick();
    check("drain_done_we", 32'(wb_q_is_rd_write), 0);

    // x0 is never tracked
    drive_issue(1, 0);
    tick();
    drive_issue(0, 0);
    id_rs2_addr = 0;
    #1;
    check("x0_pending", pending_o, 0);
    check("x0_rs2_busy", 32'(rs2_busy_o), 0);

    // simultaneous set and clear of bit 9
    drive_issue(1, 9);
    tick();
    drive_issue(0, 0);
    check("sim_pending_pre", pending_o, 32'h200);
    drive_pipe(1, 4, 32'h44);
    drive_lu(1, 9, 32'h99);
    tick();
    drive_lu(0, 0, 0);
    check_wr("sim_pipe", 1, 4, 32'h44);
    drive_pipe(0, 0, 0);
    drive_issue(1, 9);
    tick();
    drive_issue(0, 0);
    check_wr("sim_pop", 1, 9, 32'h99);
    check("sim_pending_kept", pending_o, 32'h200);
    id_rs2_addr = 9;
    #1;
    check("sim_rs2_busy", 32'(rs2_busy_o), 1);

    // reset mid-operation with one FIFO entry and x9 pending
    drive_pipe(1, 6, 32'h66);
    drive_lu(1, 12, 32'hC);
    tick();
    check_wr("rst_pre_pipe", 1, 6, 32'h66);
    drive_pipe(0, 0, 0);
    drive_lu(0, 0, 0);
    rst_ni = 1'b0;
    tick();
    check("rst_mid_pending", pending_o, 0);
    check_wr("rst_mid", 0, 0, 0);
    check("rst_mid_ready", 32'(lu_ready_o), 0);
    rst_ni = 1'b1;
    tick();
    check_wr("rst_after_1", 0, 0, 0);
    check("rst_after_ready", 32'(lu_ready_o), 1);
    tick();
    check("rst_after_2_we", 32'(wb_q_is_rd_write), 0);
    check("rst_after_pending", pending_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
